// File: rtl/wave_gen_multi.sv
`default_nettype none
// wave_gen_multi: signed triangle / saw / square generator with double-buffered runtime config.
// Revision 1.0
module wave_gen_multi #(
  parameter int WIDTH    = 16,
  parameter int DIV_W    = 16,
  parameter int RST_DIV  = 256,
  parameter int RST_STEP = 256,
  parameter int RST_LO   = -(2**(WIDTH-1)),
  parameter int RST_HI   = 2**(WIDTH-1)-1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    cfg_load,
  input  logic [1:0]              mode,
  input  logic [DIV_W-1:0]        div,
  input  logic [WIDTH-1:0]        step,
  input  logic signed [WIDTH-1:0] lo,
  input  logic signed [WIDTH-1:0] hi,
  output logic signed [WIDTH-1:0] wave_out,
  output logic                    out_valid,
  output logic                    peak,
  output logic                    trough,
  output logic                    cfg_err
);

  localparam int EW = WIDTH + 2;

  localparam logic [1:0] MODE_TRI     = 2'd0;
  localparam logic [1:0] MODE_SAW_UP  = 2'd1;
  localparam logic [1:0] MODE_SAW_DN  = 2'd2;
  localparam logic [1:0] MODE_SQUARE  = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
  } cfg_t;

  localparam cfg_t RST_CFG = '{
    mode: MODE_TRI,
    div:  DIV_W'(RST_DIV),
    step: WIDTH'(RST_STEP),
    lo:   WIDTH'(RST_LO),
    hi:   WIDTH'(RST_HI)
  };

  function automatic logic signed [EW-1:0] sx(input logic [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  cfg_t             act;
  cfg_t             pend;
  logic             pend_vld;
  dir_t             dir;
  dir_t             dir_nxt;
  logic [DIV_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;

  logic                 tick;
  logic                 ev_peak;
  logic                 ev_trough;
  logic                 cycle_start;
  logic                 apply;
  logic                 cfg_ok;
  logic [WIDTH-1:0]     tick_out;
  logic [WIDTH-1:0]     start_acc;
  logic [WIDTH-1:0]     start_out;
  logic signed [EW-1:0] acc_x;
  logic signed [EW-1:0] step_x;
  logic signed [EW-1:0] lo_x;
  logic signed [EW-1:0] hi_x;
  logic signed [EW-1:0] up_sum;
  logic signed [EW-1:0] dn_sum;
  logic signed [EW-1:0] new_lo_x;
  logic signed [EW-1:0] new_hi_x;
  logic signed [EW-1:0] new_step_x;
  cfg_t                 cfg_in;

  assign tick   = en && (cnt == act.div);
  assign acc_x  = sx(acc);
  assign step_x = {2'b00, act.step};
  assign lo_x   = sx(act.lo);
  assign hi_x   = sx(act.hi);
  assign up_sum = acc_x + step_x;
  assign dn_sum = acc_x - step_x;

  // Widened arithmetic keeps acc+step / acc-step exact, so bound tests never wrap.
  always_comb begin
    acc_nxt   = acc;
    dir_nxt   = dir;
    ev_peak   = 1'b0;
    ev_trough = 1'b0;
    unique case (act.mode)
      MODE_SAW_UP: begin
        if (up_sum > hi_x) begin
          acc_nxt = act.lo;
          ev_peak = 1'b1;
        end else begin
          acc_nxt = up_sum[WIDTH-1:0];
        end
      end
      MODE_SAW_DN: begin
        if (dn_sum < lo_x) begin
          acc_nxt   = act.hi;
          ev_trough = 1'b1;
        end else begin
          acc_nxt = dn_sum[WIDTH-1:0];
        end
      end
      MODE_TRI, MODE_SQUARE: begin
        if (dir == DIR_UP) begin
          if (up_sum >= hi_x) begin
            acc_nxt = act.hi;
            dir_nxt = DIR_DOWN;
            ev_peak = 1'b1;
          end else begin
            acc_nxt = up_sum[WIDTH-1:0];
          end
        end else begin
          if (dn_sum <= lo_x) begin
            acc_nxt   = act.lo;
            dir_nxt   = DIR_UP;
            ev_trough = 1'b1;
          end else begin
            acc_nxt = dn_sum[WIDTH-1:0];
          end
        end
      end
    endcase
  end

  always_comb begin
    tick_out = acc_nxt;
    if (act.mode == MODE_SQUARE) begin
      tick_out = (dir_nxt == DIR_UP) ? act.hi : act.lo;
    end
  end

  // A new waveform cycle starts at the trough, except saw-up which restarts at its peak wrap.
  assign cycle_start = (act.mode == MODE_SAW_UP) ? ev_peak : ev_trough;
  assign apply       = pend_vld && ((tick && cycle_start) || !en);

  always_comb begin
    start_acc = (pend.mode == MODE_SAW_DN) ? pend.hi : pend.lo;
    start_out = (pend.mode == MODE_SQUARE) ? pend.hi : start_acc;
  end

  assign cfg_in     = '{mode: mode, div: div, step: step, lo: lo, hi: hi};
  assign new_lo_x   = sx(lo);
  assign new_hi_x   = sx(hi);
  assign new_step_x = {2'b00, step};
  assign cfg_ok     = (new_lo_x < new_hi_x) && (step != '0) &&
                      (new_step_x <= (new_hi_x - new_lo_x));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act       <= RST_CFG;
      pend      <= RST_CFG;
      pend_vld  <= 1'b0;
      dir       <= DIR_UP;
      cnt       <= '0;
      acc       <= RST_CFG.lo;
      wave_out  <= RST_CFG.lo;
      out_valid <= 1'b0;
      peak      <= 1'b0;
      trough    <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      peak      <= 1'b0;
      trough    <= 1'b0;
      cfg_err   <= cfg_load && !cfg_ok;

      if (en) begin
        cnt <= tick ? '0 : cnt + 1'b1;
      end

      if (tick) begin
        acc       <= acc_nxt;
        dir       <= dir_nxt;
        wave_out  <= tick_out;
        out_valid <= 1'b1;
        peak      <= ev_peak;
        trough    <= ev_trough;
      end

      // Apply overrides the tick result but keeps the cycle-start pulse set above.
      if (apply) begin
        act       <= pend;
        acc       <= start_acc;
        dir       <= DIR_UP;
        cnt       <= '0;
        wave_out  <= start_out;
        out_valid <= 1'b1;
      end

      if (cfg_load && cfg_ok) begin
        pend     <= cfg_in;
        pend_vld <= 1'b1;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wave_gen_multi.sv
`default_nettype none
// tb_wave_gen_multi: table vectors, directed corner sequences and randomized traffic vs a behavioural model.
module tb_wave_gen_multi;

  localparam int WIDTH = 16;
  localparam int DIV_W = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    en;
  logic                    cfg_load;
  logic [1:0]              mode;
  logic [DIV_W-1:0]        div;
  logic [WIDTH-1:0]        step;
  logic signed [WIDTH-1:0] lo;
  logic signed [WIDTH-1:0] hi;
  logic signed [WIDTH-1:0] wave_out;
  logic                    out_valid;
  logic                    peak;
  logic                    trough;
  logic                    cfg_err;
  logic [3:0]              flags;

  int checks   = 0;
  int failures = 0;

  wave_gen_multi #(
    .WIDTH(WIDTH), .DIV_W(DIV_W), .RST_DIV(256), .RST_STEP(256),
    .RST_LO(-32768), .RST_HI(32767)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_load(cfg_load), .mode(mode),
    .div(div), .step(step), .lo(lo), .hi(hi), .wave_out(wave_out),
    .out_valid(out_valid), .peak(peak), .trough(trough), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  assign flags = {out_valid, peak, trough, cfg_err};

  // Reference model: plain integer arithmetic on the waveform rules.
  int   m_mode, m_div, m_step, m_lo, m_hi, m_cnt, m_acc;
  bit   m_up;
  bit   p_ok;
  int   p_mode, p_div, p_step, p_lo, p_hi;
  int   e_wave;
  logic [3:0] e_flags;

  task automatic model_reset();
    m_mode = 0; m_div = 256; m_step = 256; m_lo = -32768; m_hi = 32767;
    m_cnt = 0; m_acc = -32768; m_up = 1'b1; p_ok = 1'b0;
    e_wave = -32768; e_flags = 4'b0000;
  endtask

  task automatic model_step();
    int  l_in, h_in, s_in;
    bit  ok, tk, ev_p, ev_t, app;
    l_in = int'(lo);
    h_in = int'(hi);
    s_in = int'(step);
    ok   = (l_in < h_in) && (s_in != 0) && (s_in <= h_in - l_in);
    ev_p = 1'b0;
    ev_t = 1'b0;
    e_flags    = 4'b0000;
    e_flags[0] = cfg_load && !ok;
    tk = en && (m_cnt == m_div);
    if (en) m_cnt = tk ? 0 : m_cnt + 1;
    if (tk) begin
      case (m_mode)
        1: if (m_acc + m_step > m_hi) begin m_acc = m_lo; ev_p = 1'b1; end
           else m_acc = m_acc + m_step;
        2: if (m_acc - m_step < m_lo) begin m_acc = m_hi; ev_t = 1'b1; end
           else m_acc = m_acc - m_step;
        default: begin
          if (m_up) begin
            if (m_acc + m_step >= m_hi) begin m_acc = m_hi; m_up = 1'b0; ev_p = 1'b1; end
            else m_acc = m_acc + m_step;
          end else begin
            if (m_acc - m_step <= m_lo) begin m_acc = m_lo; m_up = 1'b1; ev_t = 1'b1; end
            else m_acc = m_acc - m_step;
          end
        end
      endcase
      e_wave     = (m_mode == 3) ? (m_up ? m_hi : m_lo) : m_acc;
      e_flags[3] = 1'b1;
      e_flags[2] = ev_p;
      e_flags[1] = ev_t;
    end
    app = p_ok && ((tk && ((m_mode == 1) ? ev_p : ev_t)) || !en);
    if (app) begin
      m_mode = p_mode; m_div = p_div; m_step = p_step; m_lo = p_lo; m_hi = p_hi;
      m_up   = 1'b1;
      m_cnt  = 0;
      m_acc  = (m_mode == 2) ? m_hi : m_lo;
      e_wave = (m_mode == 3) ? m_hi : m_acc;
      e_flags[3] = 1'b1;
      p_ok   = 1'b0;
    end
    if (cfg_load && ok) begin
      p_mode = int'(mode); p_div = int'(div); p_step = s_in; p_lo = l_in; p_hi = h_in;
      p_ok   = 1'b1;
    end
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model_wave", int'(wave_out), e_wave);
    check("model_flags", int'(flags), int'(e_flags));
  endtask

  task automatic set_cfg(input int m, input int d, input int s, input int l, input int h);
    mode = 2'(m);
    div  = DIV_W'(d);
    step = WIDTH'(s);
    lo   = WIDTH'(l);
    hi   = WIDTH'(h);
  endtask

  task automatic load_idle(input int m, input int d, input int s, input int l, input int h);
    en = 1'b0;
    set_cfg(m, d, s, l, h);
    cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0;
    cycle();
  endtask

  typedef struct packed {
    logic        en;
    logic        load;
    logic [31:0] wave;
    logic [3:0]  flags;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic ld, input int w, input logic [3:0] f);
    vec_t v;
    v.en = e; v.load = ld; v.wave = w; v.flags = f;
    return v;
  endfunction

  vec_t tbl[$];
  int   tri_seq[15] = '{-70, -40, -10, 20, 50, 80, 100, 70, 40, 10, -20, -50, -80, -100, -70};
  int   saw_seq[5]  = '{4, 8, 0, 4, 8};
  int   first;
  int   found;
  int   l_r, h_r, s_r;

  initial begin
    reset = 1'b1; en = 1'b0; cfg_load = 1'b0;
    set_cfg(0, 0, 1, 0, 1);
    model_reset();

    // Reset state, then default config with en=1: first tick lands on clock 257.
    repeat (3) @(posedge clk);
    #1;
    check("reset_wave", int'(wave_out), -32768);
    check("reset_flags", int'(flags), 0);
    reset = 1'b0;
    en    = 1'b1;
    first = 0;
    for (int n = 1; n <= 400 && first == 0; n++) begin
      cycle();
      if (out_valid) first = n;
    end
    check("first_tick_clock", first, 257);
    check("first_tick_wave", int'(wave_out), -32512);
    repeat (300) cycle();
    check("second_tick_wave", int'(wave_out), -32256);

    // Asynchronous reset mid-ramp takes effect before the next clock edge.
    reset = 1'b1;
    #1;
    check("async_rst_wave", int'(wave_out), -32768);
    check("async_rst_flags", int'(flags), 0);
    model_reset();
    en = 1'b0;
    #2;
    reset = 1'b0;

    // Table: idle load of a small triangle, then one sample per clock.
    set_cfg(0, 0, 30, -100, 100);
    tbl.push_back(mk(1'b0, 1'b1, -32768, 4'b0000));
    tbl.push_back(mk(1'b0, 1'b0, -100,   4'b1000));
    for (int i = 0; i < 15; i++) begin
      tbl.push_back(mk(1'b1, 1'b0, tri_seq[i],
                       (i == 6) ? 4'b1100 : ((i == 13) ? 4'b1010 : 4'b1000)));
    end
    foreach (tbl[i]) begin
      en       = tbl[i].en;
      cfg_load = tbl[i].load;
      cycle();
      check("tbl_wave", int'(wave_out), int'($signed(tbl[i].wave)));
      check("tbl_flags", int'(flags), int'(tbl[i].flags));
    end
    cfg_load = 1'b0;

    // Saw up, div=1: a sample every second clock, wrap to lo with peak.
    load_idle(1, 1, 4, 0, 10);
    check("saw_start_wave", int'(wave_out), 0);
    check("saw_start_valid", int'(out_valid), 1);
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      check("saw_flags", int'(flags), (k % 2 == 0) ? ((k == 6) ? 4'b1100 : 4'b1000) : 4'b0000);
      if (k % 2 == 0) check("saw_wave", int'(wave_out), saw_seq[k/2-1]);
    end

    // Square: hi/lo levels flip together with the peak/trough pulses.
    load_idle(3, 0, 30, -100, 100);
    check("sq_start_wave", int'(wave_out), 100);
    en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cycle();
      check("sq_wave", int'(wave_out), (k <= 6 || k == 14) ? 100 : -100);
      check("sq_flags", int'(flags), {1'b1, k == 7, k == 14, 1'b0});
    end

    // Rejected config: error pulse only, waveform keeps running.
    set_cfg(0, 0, 10, 50, 50);
    cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0;
    check("cfg_err_pulse", int'(cfg_err), 1);
    check("cfg_err_wave", int'(wave_out), 100);
    cycle();
    check("cfg_err_clear", int'(cfg_err), 0);
    check("cfg_err_wave2", int'(wave_out), 100);

    // Valid load mid-up-ramp waits for the trough before taking effect.
    load_idle(0, 0, 30, -100, 100);
    en = 1'b1;
    repeat (3) cycle();
    set_cfg(0, 0, 10, -20, 40);
    cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0;
    check("pend_hold_wave", int'(wave_out), 20);
    found = 0;
    for (int n = 1; n <= 40 && found == 0; n++) begin
      cycle();
      if (trough) found = n;
    end
    check("pend_trough_seen", found, 10);
    check("pend_apply_wave", int'(wave_out), -20);
    cycle();
    check("pend_new_step", int'(wave_out), -10);

    // Randomized traffic: enables, loads (some invalid), every mode and small dividers.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      cfg_load = ($urandom_range(0, 24) == 0);
      if (cfg_load) begin
        l_r = int'($urandom_range(0, 300)) - 200;
        h_r = l_r + int'($urandom_range(1, 300));
        s_r = int'($urandom_range(1, h_r - l_r));
        if ($urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 2))
            0:       h_r = l_r;
            1:       s_r = 0;
            default: s_r = h_r - l_r + 1;
          endcase
        end
        set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), s_r, l_r, h_r);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wave_gen_multi.md
Name: wave_gen_multi

Overview:
- Parametrised multi-mode waveform generator, successor to the fixed triangle source.
- Produces signed samples with configurable width, prescaler, step, amplitude bounds and waveform mode: triangle, saw up, saw down or square.
- Runtime configuration is double-buffered and applied only at waveform cycle boundaries.
- Feeds the PWM comparator / DDS mixing path.

Parameters:
WIDTH, 16, sample width (signed two's complement)
DIV_W, 16, prescaler width
RST_DIV, 256, prescaler value after reset
RST_STEP, 256, step after reset
RST_LO, -(2**(WIDTH-1)), lower bound after reset
RST_HI, 2**(WIDTH-1)-1, upper bound after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  run enable; 0 freezes prescaler and waveform
cfg_load  in  1  one-cycle strobe; capture mode/div/step/lo/hi
mode  in  2  0 triangle, 1 saw up, 2 saw down, 3 square
div  in  DIV_W  tick period = div+1 clocks
step  in  WIDTH  unsigned increment per tick
lo  in  WIDTH  signed lower bound
hi  in  WIDTH  signed upper bound
wave_out  out  WIDTH  signed sample, registered
out_valid  out  1  one-clock pulse on each sample update
peak  out  1  one-clock pulse, upper event
trough  out  1  one-clock pulse, lower event
cfg_err  out  1  one-clock pulse, rejected configuration

Behaviour:
- Reset (async, immediate):
  - Active config = RST_*, mode 0, dir = up, prescaler = 0, acc = RST_LO.
  - wave_out = RST_LO; out_valid = peak = trough = cfg_err = 0; pending config cleared.
- Prescaler:
  - When en=1, count 0..div_active; tick asserts in the cycle count==div_active, then count returns to 0.
  - div=0 gives a tick every clock. en=0 holds count; no ticks.
- Tick update: all arithmetic in WIDTH+2 signed, no overflow; acc always stays within [lo,hi].
  - Triangle, dir up: if acc+step >= hi, acc <= hi, dir <= down, peak; else acc += step.
  - Triangle, dir down: if acc-step <= lo, acc <= lo, dir <= up, trough; else acc -= step.
  - Saw up: if acc+step > hi, acc <= lo, peak; else acc += step.
  - Saw down: if acc-step < lo, acc <= hi, trough; else acc -= step.
  - Square: acc runs the triangle rule; output = hi while dir up, lo while dir down; peak/trough as triangle.
- Latency and outputs:
  - wave_out, out_valid, peak and trough all update on the clock edge ending the tick cycle.
  - out_valid is high for exactly that one clock.
- Configuration:
  - On cfg_load, inputs are validated: lo < hi, step != 0, step <= hi-lo.
  - Invalid: cfg_err pulses on the next clock, pending is unchanged, active is unchanged.
  - Valid: stored as pending; a later load overwrites an earlier pending.
- Apply point:
  - Pending becomes active at the next cycle-start event: trough for modes 0/3/2, peak for mode 1.
  - When en=0, pending applies on the next clock.
  - On apply: acc <= new lo (new hi for mode 2); dir <= up; prescaler <= 0; wave_out shows the new start value with out_valid.
  - The cycle-start pulse is still issued.
- Simultaneous cfg_load and apply event in one cycle: the existing pending applies; the new strobe is validated and becomes the next pending.
- Mode change applies only via the pending mechanism; the current cycle completes in the old mode.
- Reset mid-operation: everything returns to reset state asynchronously; pending is lost.

Test Plan:
- Reset release, en=1, defaults:
  - First tick at clock 257 with wave_out -32768 -> -32512.
  - 256th tick gives 32767 with peak; 256th tick after that gives -32768 with trough.
- en=0, load mode0 lo=-100 hi=100 step=30 div=0, then en=1:
  - wave_out -100,-70,-40,-10,20,50,80,100 (peak),70,40,10,-20,-50,-80,-100 (trough), one sample per clock.
- Load mode1 lo=0 hi=10 step=4 div=1:
  - Samples 0,4,8,0 (peak),4 every 2 clocks; out_valid every second clock.
- Mode3 with scenario-2 bounds:
  - wave_out = 100 for 7 ticks, then -100 for 7 ticks; peak/trough aligned with transitions.
- Invalid cfg_load lo=50 hi=50 -> cfg_err pulse next clock, waveform unaffected.
- Valid load mid-up-ramp with en=1 -> no change until trough, then new lo is output.
- Assert reset mid-ramp -> wave_out = -32768 before next clk edge; all flags 0.
